ks_add_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined 32-bit Kogge-Stone adder between NREQ requesters.
//  - Grants one request per cycle and drives the adder operand port.
//  - Tags each issued op with its requester ID and carries the tag down a LAT-deep pipe.
//  - Returns sum/carry-out to the owning requester.
//  - Sits between the datapath clients and the ks_1.. prefix-stage adder chain.

---
 rtl/ks_add_sched.sv | 170 +++++++++++++++++
 tb/tb_ks_add_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_add_sched.sv
// Round-robin scheduler sharing one pipelined Kogge-Stone adder between NREQ requesters.
// Optional multi-word carry chaining is compiled in with `define KS_CHAIN_EN.
module ks_add_sched #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NREQ-1:0]               i_req_valid,
  output logic [NREQ-1:0]               o_req_ready,
  input  logic [NREQ*W-1:0]             i_req_a,
  input  logic [NREQ*W-1:0]             i_req_b,
  input  logic [NREQ-1:0]               i_req_c0,
  input  logic [NREQ-1:0]               i_req_chain,
  output logic                          o_add_valid,
  output logic [W-1:0]                  o_add_a,
  output logic [W-1:0]                  o_add_b,
  output logic                          o_add_c0,
  input  logic [W-1:0]                  i_add_sum,
  input  logic                          i_add_cout,
  output logic                          o_rsp_valid,
  output logic [$clog2(NREQ)-1:0]       o_rsp_id,
  output logic [W-1:0]                  o_rsp_sum,
  output logic                          o_rsp_cout,
  output logic                          o_busy
);

  localparam int IDW = $clog2(NREQ);

  // Handshake: a request r transfers on a rising edge where i_req_valid[r] & o_req_ready[r];
  // o_req_ready never depends on anything registered after that edge, and responses have no backpressure.

  logic [IDW-1:0]  r_ptr;
  logic            r_add_valid;
  logic [W-1:0]    r_add_a;
  logic [W-1:0]    r_add_b;
  logic            r_add_c0;
  logic [IDW-1:0]  r_add_id;
  logic [LAT:1]    r_tag_v;
  logic [IDW-1:0]  r_tag_id [1:LAT];
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_sum;
  logic            r_rsp_cout;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_gnt_c0;
  logic [IDW-1:0]  w_next_ptr;

`ifdef KS_CHAIN_EN
  logic [NREQ-1:0] r_carry;
  logic [NREQ-1:0] w_inflight;

  // A chained op needs its predecessor's carry, so hold it off while that requester has work in the pipe.
  always_comb begin
    w_inflight = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (r_add_valid && (r_add_id == IDW'(r))) w_inflight[r] = 1'b1;
      for (int s = 1; s <= LAT; s++) begin
        if (r_tag_v[s] && (r_tag_id[s] == IDW'(r))) w_inflight[r] = 1'b1;
      end
    end
    w_elig = ~(i_req_chain & w_inflight);
  end

  assign w_gnt_c0 = i_req_chain[w_gnt_id] ? r_carry[w_gnt_id] : i_req_c0[w_gnt_id];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_carry <= '0;
    end else if (r_tag_v[LAT]) begin
      r_carry[r_tag_id[LAT]] <= i_add_cout;
    end
  end
`else
  logic w_unused_chain;

  assign w_elig         = '1;
  assign w_gnt_c0       = i_req_c0[w_gnt_id];
  assign w_unused_chain = ^i_req_chain;
`endif

  // Scan from the pointer downwards in priority so the nearest candidate (wrapping) wins.
  always_comb begin
    int j;
    j         = 0;
    w_gnt     = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (i_req_valid[j] && w_elig[j]) begin
        w_gnt     = '0;
        w_gnt[j]  = 1'b1;
        w_gnt_id  = j[IDW-1:0];
        w_gnt_any = 1'b1;
      end
    end
  end

  assign w_next_ptr  = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
  assign o_req_ready = w_gnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_add_valid <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_c0    <= 1'b0;
      r_add_id    <= '0;
    end else begin
      r_add_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_ptr    <= w_next_ptr;
        r_add_a  <= i_req_a[w_gnt_id*W +: W];
        r_add_b  <= i_req_b[w_gnt_id*W +: W];
        r_add_c0 <= w_gnt_c0;
        r_add_id <= w_gnt_id;
      end
    end
  end

  // Stage s of the tag pipe describes the op whose adder result is s cycles past issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_v <= '0;
      for (int s = 1; s <= LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_v[1]  <= r_add_valid;
      r_tag_id[1] <= r_add_id;
      for (int s = 2; s <= LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      r_rsp_valid <= r_tag_v[LAT];
      if (r_tag_v[LAT]) begin
        r_rsp_id   <= r_tag_id[LAT];
        r_rsp_sum  <= i_add_sum;
        r_rsp_cout <= i_add_cout;
      end
    end
  end

  assign o_add_valid = r_add_valid;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_c0    = r_add_c0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
  assign o_busy      = r_add_valid | (|r_tag_v) | r_rsp_valid;

endmodule

// File: tb/tb_ks_add_sched.sv
// Directed bench for ks_add_sched (NREQ=4, W=32, LAT=3) with a 3-stage adder model.
module tb_ks_add_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int RW   = IDW + 1 + W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_c0 = '0;
  logic [NREQ-1:0]     req_chain = '0;
  logic                add_valid;
  logic [W-1:0]        add_a;
  logic [W-1:0]        add_b;
  logic                add_c0;
  logic [W-1:0]        add_sum;
  logic                add_cout;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_sum;
  logic                rsp_cout;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] rsp_q[$];
  int            rsp_cyc_q[$];

  ks_add_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_c0(req_c0), .i_req_chain(req_chain),
    .o_add_valid(add_valid), .o_add_a(add_a), .o_add_b(add_b), .o_add_c0(add_c0),
    .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout),
    .o_busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adder model: LAT register stages between operand port and result
  logic [W:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};
    p2 <= p1;
    p3 <= p2;
  end
  assign add_sum  = p3[W-1:0];
  assign add_cout = p3[W];

  // response monitor
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_q.push_back({rsp_id, rsp_cout, rsp_sum});
      rsp_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c0, input logic ch);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_c0[r]       = c0;
    req_chain[r]    = ch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c0    = '0;
    req_chain = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    rsp_cyc_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_vec++; if (add_valid !== 1'b0) begin n_err++; $display("FAIL reset_add_valid: got %b want 0", add_valid); end
    n_vec++; if (add_a !== 32'h0) begin n_err++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_sum !== 32'h0) begin n_err++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    do_reset();
    @(negedge clk);
    set_req(0, 32'd5, 32'd7, 1'b1, 1'b0);
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = '0;
        n_vec++; if ({add_valid, add_a, add_b, add_c0} !== {1'b1, 32'd5, 32'd7, 1'b1}) begin
          n_err++; $display("FAIL single_issue: got v=%b a=%h b=%h c0=%b want 1/5/7/1", add_valid, add_a, add_b, add_c0);
        end
      end
      if (rsp_valid && lat == 0) lat = i;
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", lat); end
    n_vec++; if (rsp_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", rsp_q.size()); end
    else begin
      n_vec++; if (rsp_q[0] !== {2'd0, 1'b0, 32'd13}) begin n_err++; $display("FAIL single_rsp: got %h want %h", rsp_q[0], {2'd0, 1'b0, 32'd13}); end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, r, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      n_vec++; if (req_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'b0001 << (i % 4)); end
      if (i > 0) begin
        n_vec++; if ({add_valid, add_a} !== {1'b1, 32'((i - 1) % 4)}) begin
          n_err++; $display("FAIL rr_issue%0d: got v=%b a=%h want 1/%0d", i, add_valid, add_a, (i - 1) % 4);
        end
      end
      exp_q.push_back({2'(i % 4), 1'b0, 32'h10 + 32'(i % 4)});
    end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if ({add_valid, add_a} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL rr_last_issue: got v=%b a=%h want 1/3", add_valid, add_a); end
    @(negedge clk);
    n_vec++; if ({add_valid, add_a} !== {1'b0, 32'd3}) begin n_err++; $display("FAIL rr_hold: got v=%b a=%h want 0/3", add_valid, add_a); end
    wait_cycles(8);
    n_vec++; if (rsp_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rr_count: got %0d want %0d", rsp_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
      n_vec++; if (rsp_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_rsp%0d: got %h want %h", i, rsp_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rsp_cyc_q.size(); i++) begin
      n_vec++; if (rsp_cyc_q[i] - rsp_cyc_q[i-1] !== 1) begin n_err++; $display("FAIL rr_b2b%0d: got gap %0d want 1", i, rsp_cyc_q[i] - rsp_cyc_q[i-1]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge clk);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ovf_ready0: got %b want 0010", req_ready); end
    @(negedge clk);
    set_req(1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ovf_ready1: got %b want 0010", req_ready); end
    n_vec++; if ({add_b, add_c0} !== {32'd1, 1'b0}) begin n_err++; $display("FAIL ovf_issue0: got b=%h c0=%b want 1/0", add_b, add_c0); end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if ({add_b, add_c0} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL ovf_issue1: got b=%h c0=%b want 0/1", add_b, add_c0); end
    exp_q.push_back({2'd1, 1'b1, 32'h0});
    exp_q.push_back({2'd1, 1'b1, 32'h0});
    wait_cycles(8);
    n_vec++; if (rsp_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", rsp_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
      n_vec++; if (rsp_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_rsp%0d: got %h want %h", i, rsp_q[i], exp_q[i]); end
    end
  endtask

`ifdef KS_CHAIN_EN
  task automatic test_chain();
    do_reset();
    @(negedge clk);
    set_req(2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL chain_ready_first: got %b want 0100", req_ready); end
    @(negedge clk);
    set_req(2, 32'd0, 32'd0, 1'b0, 1'b1);
    set_req(0, 32'd3, 32'd4, 1'b0, 1'b0);
    req_valid = 4'b0101;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL chain_r0_meanwhile: got %b want 0001", req_ready); end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL chain_blocked%0d: got %b want 0000", i, req_ready); end
    end
    @(negedge clk);
    #1;
    n_vec++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0100}) begin
      n_err++; $display("FAIL chain_release: got rsp=%b ready=%b want 1/0100", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if ({add_valid, add_a, add_c0} !== {1'b1, 32'd0, 1'b1}) begin
      n_err++; $display("FAIL chain_c0: got v=%b a=%h c0=%b want 1/0/1", add_valid, add_a, add_c0);
    end
    exp_q.push_back({2'd2, 1'b1, 32'd0});
    exp_q.push_back({2'd0, 1'b0, 32'd7});
    exp_q.push_back({2'd2, 1'b0, 32'd1});
    wait_cycles(8);
    n_vec++; if (rsp_q.size() !== exp_q.size()) begin n_err++; $display("FAIL chain_count: got %0d want %0d", rsp_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
      n_vec++; if (rsp_q[i] !== exp_q[i]) begin n_err++; $display("FAIL chain_rsp%0d: got %h want %h", i, rsp_q[i], exp_q[i]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, 32'h40 + r, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'b0111;
      #1;
      n_vec++; if (req_ready !== (4'b0001 << i)) begin n_err++; $display("FAIL rstmid_grant%0d: got %b want %b", i, req_ready, 4'b0001 << i); end
    end
    @(negedge clk);
    req_valid = '0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if ({busy, add_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid_cleared: got busy=%b v=%b want 0/0", busy, add_valid); end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(8);
    n_vec++; if (rsp_q.size() !== 0) begin n_err++; $display("FAIL rstmid_no_rsp: got %0d rsp want 0", rsp_q.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", busy); end
    req_valid = 4'b1110;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rstmid_ptr0: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_cycles(7);
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    set_req(0, 32'h100, 32'd1, 1'b0, 1'b0);
    set_req(1, 32'h200, 32'd1, 1'b0, 1'b0);
    set_req(3, 32'h800, 32'd1, 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap%0d_r1: got %b want 0010", pass, req_ready); end
      @(negedge clk);
      req_valid = 4'b1001;
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap%0d_r3: got %b want 1000", pass, req_ready); end
      @(negedge clk);
      req_valid = (pass == 0) ? 4'b0001 : 4'b0000;
      #1;
      n_vec++; if (req_ready !== req_valid) begin n_err++; $display("FAIL wrap%0d_after_r3: got %b want %b", pass, req_ready, req_valid); end
      @(negedge clk);
      if (pass == 1) begin
        n_vec++; if (add_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drop_no_issue: got %b want 0", add_valid); end
        req_valid = 4'b0101;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ptr_held: got %b want 0001", req_ready); end
        @(negedge clk);
      end
      req_valid = '0;
      exp_q.push_back({2'd1, 1'b0, 32'h201});
      exp_q.push_back({2'd3, 1'b0, 32'h801});
      exp_q.push_back({2'd0, 1'b0, 32'h101});
    end
    wait_cycles(8);
    n_vec++; if (rsp_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", rsp_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
      n_vec++; if (rsp_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_rsp%0d: got %h want %h", i, rsp_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
`ifdef KS_CHAIN_EN
    test_chain();
`endif
    test_reset_mid();
    test_pointer_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
